// File: rtl/sat_add_if.sv
// Request/response bundle between the requesters and the shared saturating adder.
interface sat_add_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*32-1:0] req_a;
    logic [NUM_REQ*32-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [31:0]           rsp_sum;
    logic                  rsp_sat;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_sat
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_sat
    );
endinterface

// File: rtl/sat_add_arbiter.sv
// Round-robin shared Q15.16 saturating adder with a registered, id-tagged response
// and a sticky saturation-event counter.
module sat_add_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    sat_add_if.slave         bus,
    input  logic             sat_clr,
    output logic [CNT_W-1:0] sat_cnt
);
    logic [ID_W-1:0]  rr_ptr_q;
    logic             rsp_valid_q;
    logic [ID_W-1:0]  rsp_id_q;
    logic [31:0]      rsp_sum_q;
    logic             rsp_sat_q;
    logic [CNT_W-1:0] sat_cnt_q;

    logic             free;
    logic             gnt_found;
    logic [ID_W-1:0]  gnt_idx;
    logic             accept;
    logic [31:0]      op_a;
    logic [31:0]      op_b;
    logic [32:0]      sum_ext;
    logic [31:0]      sum_d;
    logic             sat_d;
    logic             sat_hs;

    // Grants are suppressed during reset so every output reads zero while rst is high.
    assign free = !rst && (!rsp_valid_q || bus.rsp_ready);

    always_comb begin
        int unsigned idx;
        gnt_found     = 1'b0;
        gnt_idx       = '0;
        idx           = 0;
        bus.req_ready = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(rr_ptr_q) + k) % NUM_REQ;
            if (!gnt_found && bus.req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = ID_W'(idx);
            end
        end
        if (free && gnt_found) begin
            bus.req_ready[gnt_idx] = 1'b1;
        end
    end

    assign accept = free && gnt_found;

    always_comb begin
        op_a    = bus.req_a[int'(gnt_idx)*32 +: 32];
        op_b    = bus.req_b[int'(gnt_idx)*32 +: 32];
        sum_ext = {op_a[31], op_a} + {op_b[31], op_b};
        sum_d   = sum_ext[31:0];
        sat_d   = 1'b0;
        // Carry-out disagreeing with the sign bit means the true sum left the range.
        if (sum_ext[32] != sum_ext[31]) begin
            sat_d = 1'b1;
            sum_d = sum_ext[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_sat_q   <= 1'b0;
        end else if (accept) begin
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= gnt_idx;
            rsp_sum_q   <= sum_d;
            rsp_sat_q   <= sat_d;
            rr_ptr_q    <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end else if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign sat_hs = rsp_valid_q && bus.rsp_ready && rsp_sat_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_cnt_q <= '0;
        end else if (sat_clr) begin
            sat_cnt_q <= '0;
        end else if (sat_hs && (sat_cnt_q != {CNT_W{1'b1}})) begin
            sat_cnt_q <= sat_cnt_q + 1'b1;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_sum   = rsp_sum_q;
    assign bus.rsp_sat   = rsp_sat_q;
    assign sat_cnt       = sat_cnt_q;
endmodule

// File: tb/tb_sat_add_arbiter.sv
// Directed bench for sat_add_arbiter: arithmetic, round-robin order, backpressure,
// saturation counter and mid-stream reset.
module tb_sat_add_arbiter;
    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned ID_W    = 2;
    localparam int unsigned CNT_W   = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             sat_clr = 1'b0;
    logic [CNT_W-1:0] sat_cnt;
    int               checks = 0;
    int               errors = 0;

    sat_add_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    sat_add_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .sat_clr (sat_clr),
        .sat_cnt (sat_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
        bus.req_a[i*32 +: 32] = a;
        bus.req_b[i*32 +: 32] = b;
        bus.req_valid[i]      = 1'b1;
    endtask

    task automatic check_rsp(input string tag, input logic v, input logic [31:0] id,
                             input logic [31:0] sum, input logic sat);
        check({tag, "_valid"}, 32'(bus.rsp_valid), 32'(v));
        check({tag, "_id"},    32'(bus.rsp_id), id);
        check({tag, "_sum"},   bus.rsp_sum, sum);
        check({tag, "_sat"},   32'(bus.rsp_sat), 32'(sat));
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;
        #1;
        check_rsp("reset", 1'b0, 0, 32'h0, 1'b0);
        check("reset_cnt", 32'(sat_cnt), 0);
        check("reset_rdy", 32'(bus.req_ready), 0);
        step();
        step();
        rst = 1'b0;

        // 1.5 + 2.25 on requester 1
        set_req(1, 32'h0001_8000, 32'h0002_4000);
        #1;
        check("t1_rdy", 32'(bus.req_ready), 32'h2);
        step();
        bus.req_valid = '0;
        check_rsp("t1", 1'b1, 1, 32'h0003_C000, 1'b0);
        step();
        check("t1_drain", 32'(bus.rsp_valid), 0);

        // Positive overflow on req0 (pointer is at 2, wraps to 0)
        set_req(0, 32'h7FFF_0000, 32'h0002_0000);
        #1;
        check("t2p_rdy", 32'(bus.req_ready), 32'h1);
        step();
        bus.req_valid = '0;
        check_rsp("t2p", 1'b1, 0, 32'h7FFF_FFFF, 1'b1);
        check("t2p_cnt0", 32'(sat_cnt), 0);
        // Negative overflow on req2, accepted while the previous result drains
        set_req(2, 32'h8000_0000, 32'h8000_0000);
        #1;
        check("t2n_rdy", 32'(bus.req_ready), 32'h4);
        step();
        bus.req_valid = '0;
        check_rsp("t2n", 1'b1, 2, 32'h8000_0000, 1'b1);
        check("t2n_cnt1", 32'(sat_cnt), 1);
        step();
        check("t2_cnt2", 32'(sat_cnt), 2);

        // Reset between tests to restart round-robin from requester 0
        rst = 1'b1;
        #1;
        check("rst2_cnt", 32'(sat_cnt), 0);
        step();
        rst = 1'b0;

        // 3. All four valid: grants 0,1,2,3,0,1,2,3
        for (int i = 0; i < 4; i++) set_req(i, 32'(i) << 16, 32'h0000_8000);
        for (int k = 0; k < 8; k++) begin
            #1;
            check("t3_rdy", 32'(bus.req_ready), 32'(1) << (k % 4));
            step();
            check_rsp("t3", 1'b1, 32'(k % 4), (32'(k % 4) << 16) | 32'h8000, 1'b0);
        end

        // 4. Backpressure with result from requester 3 pending
        bus.rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("t4_rdy", 32'(bus.req_ready), 0);
            step();
            check_rsp("t4_hold", 1'b1, 3, 32'h0003_8000, 1'b0);
        end
        bus.rsp_ready = 1'b1;
        #1;
        check("t4_release_rdy", 32'(bus.req_ready), 32'h1);
        step();
        bus.req_valid = '0;
        check_rsp("t4_next", 1'b1, 0, 32'h0000_8000, 1'b0);
        step();

        // 5. Twenty saturating results from requester 0; counter sticks at 15
        set_req(0, 32'h7FFF_0000, 32'h7FFF_0000);
        for (int n = 1; n <= 20; n++) begin
            step();
            check("t5_cnt", 32'(sat_cnt), (n - 1 > 15) ? 32'd15 : 32'(n - 1));
        end
        bus.req_valid = '0;
        sat_clr       = 1'b1;
        step();
        sat_clr = 1'b0;
        check("t5_clr_at_max", 32'(sat_cnt), 0);
        check("t5_drained", 32'(bus.rsp_valid), 0);
        set_req(0, 32'h8000_0000, 32'hFFFF_0000);
        step();
        bus.req_valid = '0;
        step();
        check("t5_cnt_one", 32'(sat_cnt), 1);
        set_req(0, 32'h8000_0000, 32'hFFFF_0000);
        step();
        bus.req_valid = '0;
        sat_clr       = 1'b1;
        step();
        sat_clr = 1'b0;
        check("t5_clr_wins", 32'(sat_cnt), 0);

        // 6. Reset mid-stream with a pending result
        for (int i = 0; i < 4; i++) set_req(i, 32'(i) << 16, 32'h0000_0001);
        bus.rsp_ready = 1'b0;
        step();
        check("t6_pending", 32'(bus.rsp_valid), 1);
        rst = 1'b1;
        #1;
        check_rsp("t6_rst", 1'b0, 0, 32'h0, 1'b0);
        check("t6_rst_rdy", 32'(bus.req_ready), 0);
        step();
        rst           = 1'b0;
        bus.rsp_ready = 1'b1;
        #1;
        check("t6_first_rdy", 32'(bus.req_ready), 32'h1);
        step();
        bus.req_valid = '0;
        check_rsp("t6_first", 1'b1, 0, 32'h0000_0001, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
